// File: rtl/icb_sram_slave.sv
// ICB target fronting a word-addressed SRAM window with byte-masked writes,
// in-order responses through an OSD-entry queue, and error responses for misses.
//   state   | meaning
//   EMPTY   | r_count == 0, no response pending
//   PARTIAL | 0 < r_count < OSD
//   FULL    | r_count == OSD, commands stalled unless a pop happens this cycle
module icb_sram_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          DEPTH     = 1024,
   parameter int          AW        = 10,
   parameter int          OSD       = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        icb_cmd_valid,
   output logic        icb_cmd_ready,
   input  logic [31:0] icb_cmd_addr,
   input  logic        icb_cmd_read,
   input  logic [31:0] icb_cmd_wdata,
   input  logic [3:0]  icb_cmd_wmask,
   output logic        icb_rsp_valid,
   input  logic        icb_rsp_ready,
   output logic [31:0] icb_rsp_rdata,
   output logic        icb_rsp_err
);

   localparam int PW = (OSD > 1) ? $clog2(OSD) : 1;
   localparam int CW = $clog2(OSD + 1);

   logic [31:0]   r_mem [DEPTH];
   logic [31:0]   r_q_rdata [OSD];
   logic          r_q_err [OSD];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   logic          w_accept;
   logic          w_pop;
   logic          w_aligned;
   logic          w_above;
   logic [29:0]   w_word;
   logic          w_hit;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_mem_rd;
   logic          w_wr_en;
   logic [PW-1:0] w_rptr_prev;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(OSD - 1)) ? '0 : p + PW'(1);
   endfunction

   // Subtraction is done before the range check; the explicit >= test keeps
   // addresses below the window from wrapping into a hit.
   assign w_aligned = (icb_cmd_addr[1:0] == 2'b00);
   assign w_above   = (icb_cmd_addr >= BASE_ADDR);
   assign w_word    = 30'((icb_cmd_addr - BASE_ADDR) >> 2);
   assign w_hit     = w_above & w_aligned & (w_word < 30'(DEPTH));
   assign w_idx     = w_word[AW-1:0];
   assign w_mem_rd  = r_mem[w_idx];

   assign icb_cmd_ready = ~rst & ((r_count < CW'(OSD)) | w_pop);
   assign w_accept      = icb_cmd_valid & icb_cmd_ready;
   assign w_pop         = icb_rsp_valid & icb_rsp_ready;
   assign w_wr_en       = w_accept & w_hit & ~icb_cmd_read;

   // When empty, show the most recently popped entry so outputs stay put.
   assign w_rptr_prev   = (r_rptr == '0) ? PW'(OSD - 1) : r_rptr - PW'(1);
   assign icb_rsp_valid = (r_count != '0);
   assign icb_rsp_rdata = icb_rsp_valid ? r_q_rdata[r_rptr] : r_q_rdata[w_rptr_prev];
   assign icb_rsp_err   = icb_rsp_valid ? r_q_err[r_rptr]   : r_q_err[w_rptr_prev];

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (icb_cmd_wmask[b]) r_mem[w_idx][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < OSD; i++) begin
            r_q_rdata[i] <= '0;
            r_q_err[i]   <= 1'b0;
         end
      end else begin
         if (w_accept) begin
            r_q_rdata[r_wptr] <= (w_hit & icb_cmd_read) ? w_mem_rd : 32'h0;
            r_q_err[r_wptr]   <= ~w_hit;
            r_wptr            <= ptr_inc(r_wptr);
         end
         if (w_pop) r_rptr <= ptr_inc(r_rptr);
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_icb_sram_slave.sv
// Scoreboard bench for icb_sram_slave: a reference memory model predicts every
// response at accept time; a monitor pops and compares on each response handshake.
module tb_icb_sram_slave;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam int          NW   = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        icb_cmd_valid;
   logic        icb_cmd_ready;
   logic [31:0] icb_cmd_addr;
   logic        icb_cmd_read;
   logic [31:0] icb_cmd_wdata;
   logic [3:0]  icb_cmd_wmask;
   logic        icb_rsp_valid;
   logic        icb_rsp_ready;
   logic [31:0] icb_rsp_rdata;
   logic        icb_rsp_err;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [32:0] sb [$];
   logic [31:0] model [NW];

   icb_sram_slave dut (
      .clk           (clk),
      .rst           (rst),
      .icb_cmd_valid (icb_cmd_valid),
      .icb_cmd_ready (icb_cmd_ready),
      .icb_cmd_addr  (icb_cmd_addr),
      .icb_cmd_read  (icb_cmd_read),
      .icb_cmd_wdata (icb_cmd_wdata),
      .icb_cmd_wmask (icb_cmd_wmask),
      .icb_rsp_valid (icb_rsp_valid),
      .icb_rsp_ready (icb_rsp_ready),
      .icb_rsp_rdata (icb_rsp_rdata),
      .icb_rsp_err   (icb_rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: predicts {err, rdata} and applies writes to the model.
   function automatic logic [32:0] predict(input logic [31:0] a, input logic rd,
                                           input logic [31:0] wd, input logic [3:0] wm);
      int idx;
      if (a < BASE || a >= BASE + 32'(4 * NW) || a[1:0] != 2'b00) return {1'b1, 32'h0};
      idx = int'((a - BASE) / 4);
      if (rd) return {1'b0, model[idx]};
      for (int b = 0; b < 4; b++) if (wm[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
      return {1'b0, 32'h0};
   endfunction

   always @(negedge clk) begin
      if (!rst && icb_rsp_valid && icb_rsp_ready) begin
         if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
         else begin
            logic [32:0] e;
            e = sb.pop_front();
            chk("rsp_rdata", icb_rsp_rdata, e[31:0]);
            chk("rsp_err", {31'd0, icb_rsp_err}, {31'd0, e[32]});
         end
      end
   end

   // Drives one command from #1 after a posedge; returns #1 after its accept edge.
   task automatic send(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                       input logic [3:0] wm, output int waits);
      bit done = 0;
      waits         = 0;
      icb_cmd_valid = 1'b1;
      icb_cmd_addr  = a;
      icb_cmd_read  = rd;
      icb_cmd_wdata = wd;
      icb_cmd_wmask = wm;
      while (!done) begin
         @(negedge clk);
         if (icb_cmd_ready) begin
            sb.push_back(predict(a, rd, wd, wm));
            done = 1;
         end else begin
            waits++;
            if (waits >= 40) begin
               chk("cmd_timeout", 32'd0, 32'd1);
               done = 1;
            end
         end
         @(posedge clk); #1;
      end
      icb_cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", sb.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int stalls;
      int gaps;
      rst = 1'b1;
      icb_cmd_valid = 1'b0; icb_cmd_addr = '0; icb_cmd_read = 1'b0;
      icb_cmd_wdata = '0;   icb_cmd_wmask = '0; icb_rsp_ready = 1'b0;
      for (int i = 0; i < NW; i++) model[i] = 32'h0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rsp_valid", {31'd0, icb_rsp_valid}, 32'd0);
      chk("rst_cmd_ready", {31'd0, icb_cmd_ready}, 32'd0);
      chk("rst_rdata", icb_rsp_rdata, 32'd0);
      chk("rst_err", {31'd0, icb_rsp_err}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", {31'd0, icb_cmd_ready}, 32'd1);

      // Basic write then read, both visible the cycle after accept
      icb_rsp_ready = 1'b1;
      @(posedge clk); #1;
      send(BASE, 1'b0, 32'h0403_0201, 4'hF, w);
      chk("wr_latency", {31'd0, icb_rsp_valid}, 32'd1);
      chk("wr_err", {31'd0, icb_rsp_err}, 32'd0);
      send(BASE, 1'b1, 32'h0, 4'h0, w);
      chk("rd_latency", {31'd0, icb_rsp_valid}, 32'd1);
      chk("rd_data", icb_rsp_rdata, 32'h0403_0201);
      drain();

      // Byte mask merge
      send(BASE + 32'h14, 1'b0, 32'hAABB_CCDD, 4'hF, w);
      send(BASE + 32'h14, 1'b0, 32'h1122_3344, 4'b0101, w);
      send(BASE + 32'h14, 1'b1, 32'h0, 4'h0, w);
      chk("mask_data", icb_rsp_rdata, 32'hAA22_CC44);
      drain();

      // Back-pressure: queue fills at 2, third accepted alongside first pop
      icb_rsp_ready = 1'b0;
      send(BASE, 1'b1, 32'h0, 4'h0, w);
      send(BASE + 32'h14, 1'b1, 32'h0, 4'h0, w);
      chk("bp_second_wait", w, 32'd0);
      icb_cmd_valid = 1'b1; icb_cmd_addr = BASE + 32'h14; icb_cmd_read = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_full_ready", {31'd0, icb_cmd_ready}, 32'd0);
         chk("bp_valid_held", {31'd0, icb_rsp_valid}, 32'd1);
         chk("bp_rdata_held", icb_rsp_rdata, 32'h0403_0201);
      end
      @(posedge clk); #1;
      icb_rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_on_pop", {31'd0, icb_cmd_ready}, 32'd1);
      if (icb_cmd_ready) sb.push_back(predict(BASE + 32'h14, 1'b1, 32'h0, 4'h0));
      @(posedge clk); #1;
      icb_cmd_valid = 1'b0;
      drain();

      // Error responses; misaligned write must not touch mem[0]
      send(BASE + 32'h1000, 1'b1, 32'h0, 4'h0, w);
      chk("err_oow", {31'd0, icb_rsp_err}, 32'd1);
      chk("err_oow_rdata", icb_rsp_rdata, 32'd0);
      send(32'h3FFF_FFFC, 1'b1, 32'h0, 4'h0, w);
      chk("err_below", {31'd0, icb_rsp_err}, 32'd1);
      send(BASE + 32'h2, 1'b0, 32'hFFFF_FFFF, 4'hF, w);
      chk("err_misaligned", {31'd0, icb_rsp_err}, 32'd1);
      send(BASE, 1'b1, 32'h0, 4'h0, w);
      chk("err_mem0_kept", icb_rsp_rdata, 32'h0403_0201);
      drain();

      // Streaming: preload then back-to-back reads
      for (int k = 0; k < 544; k++) send(BASE + 32'(4 * k), 1'b0, $urandom, 4'hF, w);
      drain();
      stalls = 0;
      gaps   = 0;
      for (int k = 0; k < 544; k++) begin
         send(BASE + 32'(4 * k), 1'b1, 32'h0, 4'h0, w);
         stalls += w;
         if (!icb_rsp_valid) gaps++;
      end
      chk("stream_stalls", stalls, 32'd0);
      chk("stream_gaps", gaps, 32'd0);
      drain();

      // Reset with two responses queued
      icb_rsp_ready = 1'b0;
      send(BASE + 32'h8, 1'b1, 32'h0, 4'h0, w);
      send(BASE + 32'hC, 1'b1, 32'h0, 4'h0, w);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("mid_rst_ready", {31'd0, icb_cmd_ready}, 32'd0);
      @(posedge clk); #1;
      chk("mid_rst_valid", {31'd0, icb_rsp_valid}, 32'd0);
      chk("mid_rst_rdata", icb_rsp_rdata, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_mid_rst_valid", {31'd0, icb_rsp_valid}, 32'd0);
      chk("post_mid_rst_ready", {31'd0, icb_cmd_ready}, 32'd1);
      icb_rsp_ready = 1'b1;
      @(posedge clk); #1;
      send(BASE + 32'h8, 1'b1, 32'h0, 4'h0, w);
      chk("rst_retained", icb_rsp_rdata, model[2]);
      drain();

      chk("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
